melody_sequencer: RTL and testbench



---
 rtl/melody_sequencer_if.sv | 45 ++++
 rtl/melody_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_melody_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/melody_sequencer_if.sv
// ---------------------------------------------------------------------------
// melody_sequencer_if
//
// Purpose: groups the melody ROM bus and the tone generator handshake used by
// melody_sequencer.
//
// Signals:
//   rom_addr    [ADDR_W-1:0] melody ROM address (sequencer -> ROM)
//   rom_data    [19:0]       ROM word, one cycle after rom_addr changes
//                            ([19:8] half-period, [7:0] duration ticks)
//   tone_period [11:0]       half-period presented to the tone generator
//   tone_valid               tone_period valid
//   tone_ready               generator accepts tone_period
//   tone_en                  generator output enable (audible)
//
// Modports: master = sequencer side, slave = ROM / tone generator side.
// ---------------------------------------------------------------------------
interface melody_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] rom_addr;
    logic [19:0]       rom_data;
    logic [11:0]       tone_period;
    logic              tone_valid;
    logic              tone_ready;
    logic              tone_en;

    modport master (
        output rom_addr,
        input  rom_data,
        output tone_period,
        output tone_valid,
        input  tone_ready,
        output tone_en
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  tone_period,
        input  tone_valid,
        output tone_ready,
        input  tone_en
    );
endinterface

// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
//
// Purpose: steps through a melody table in an external synchronous ROM and
// schedules each note onto the square-wave tone generator. Each note loads a
// half-period over a valid/ready handshake, holds the tone for a number of
// duration ticks, then inserts a silent gap. A word with duration 0 ends the
// song; a word with period 0 and nonzero duration is a silent rest.
//
// Parameters:
//   ADDR_W     melody ROM address width
//   TICK_DIV   clk_100m cycles per duration tick (>= 2)
//   GAP_TICKS  silent ticks after each note (0 = no gap)
//
// Ports:
//   clk_100m   system clock
//   btn_rst    asynchronous active-high reset
//   start      one-cycle pulse: begin playback at address 0
//   stop       one-cycle pulse: abort playback
//   bus        melody_sequencer_if.master (ROM bus + tone generator handshake)
//   busy       high whenever not idle
//   note_idx   address of the note currently loaded/playing
//   song_done  one-cycle pulse at end of song
//
// Optional feature: define MELODY_LOOP_EN to replay the song from address 0
// after every end of song instead of returning to idle.
// ---------------------------------------------------------------------------
module melody_sequencer #(
    parameter int ADDR_W    = 6,
    parameter int TICK_DIV  = 1562500,
    parameter int GAP_TICKS = 1
) (
    input  logic                 clk_100m,
    input  logic                 btn_rst,
    input  logic                 start,
    input  logic                 stop,
    melody_sequencer_if.master   bus,
    output logic                 busy,
    output logic [ADDR_W-1:0]    note_idx,
    output logic                 song_done
);

    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam bit                HAS_GAP   = (GAP_TICKS > 0);
    localparam logic [7:0]        GAP_LAST  = 8'(HAS_GAP ? GAP_TICKS - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [11:0]        period_q;
    logic [7:0]         note_dur;
    logic               is_rest;
    logic [TICK_W-1:0]  tick_cnt;
    logic [7:0]         dur_cnt;

    logic [11:0]        rom_period;
    logic [7:0]         rom_dur;
    logic               tick_wrap;
    logic               play_last;
    logic               gap_last;

    assign rom_period = bus.rom_data[19:8];
    assign rom_dur    = bus.rom_data[7:0];

    // A tick ends when the cycle counter wraps; a phase ends on the wrap of
    // its final tick, so PLAY lasts exactly duration*TICK_DIV cycles.
    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign play_last = tick_wrap && (dur_cnt == note_dur - 8'd1);
    assign gap_last  = tick_wrap && (dur_cnt == GAP_LAST);

    assign bus.rom_addr    = rom_addr_q;
    assign bus.tone_period = period_q;

    // Next-state logic and state-decoded outputs. stop overrides every
    // transition out of a non-idle state, which is also the only way
    // tone_valid can fall without a completed handshake.
    always_comb begin
        next_state     = state;
        busy           = 1'b0;
        bus.tone_valid = 1'b0;
        bus.tone_en    = 1'b0;
        song_done      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start && !stop) next_state = S_FETCH;
            end
            S_FETCH: begin
                next_state = S_DECODE;
            end
            S_DECODE: begin
                if (rom_dur == 8'd0)           next_state = S_DONE;
                else if (rom_period == 12'd0)  next_state = S_PLAY;
                else                           next_state = S_LOAD;
            end
            S_LOAD: begin
                if (bus.tone_ready) next_state = S_PLAY;
            end
            S_PLAY: begin
                if (play_last) next_state = HAS_GAP ? S_GAP : S_NEXT;
            end
            S_GAP: begin
                if (gap_last) next_state = S_NEXT;
            end
            S_NEXT: begin
                // The last ROM entry ends the song rather than wrapping to 0.
                if (rom_addr_q == ADDR_LAST) next_state = S_DONE;
                else                         next_state = S_FETCH;
            end
            S_DONE: begin
`ifdef MELODY_LOOP_EN
                next_state = S_FETCH;
`else
                next_state = S_IDLE;
`endif
            end
            default: next_state = S_IDLE;
        endcase

        if (stop && state != S_IDLE) next_state = S_IDLE;

        busy           = (state != S_IDLE);
        bus.tone_valid = (state == S_LOAD);
        bus.tone_en    = (state == S_PLAY) && !is_rest;
        song_done      = (state == S_DONE);
    end

    // State register, ROM addressing, note latch and tick/duration counters.
    always_ff @(posedge clk_100m or posedge btn_rst) begin
        if (btn_rst) begin
            state      <= S_IDLE;
            rom_addr_q <= '0;
            period_q   <= '0;
            note_idx   <= '0;
            note_dur   <= '0;
            is_rest    <= 1'b0;
            tick_cnt   <= '0;
            dur_cnt    <= '0;
        end else begin
            state <= next_state;

            // A fresh pass (from idle or from a looping end of song) starts at 0.
            if (next_state == S_FETCH && (state == S_IDLE || state == S_DONE))
                rom_addr_q <= '0;
            else if (state == S_NEXT && next_state == S_FETCH)
                rom_addr_q <= rom_addr_q + 1'b1;

            // Rests keep the previous period so tone_period never glitches.
            if (state == S_DECODE) begin
                note_idx <= rom_addr_q;
                note_dur <= rom_dur;
                is_rest  <= (rom_period == 12'd0);
                if (rom_period != 12'd0) period_q <= rom_period;
            end

            // Counters only run while staying in PLAY or GAP; any transition
            // clears them so each timed phase starts from zero.
            if ((state == S_PLAY || state == S_GAP) && next_state == state) begin
                if (tick_wrap) begin
                    tick_cnt <= '0;
                    dur_cnt  <= dur_cnt + 8'd1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end else begin
                tick_cnt <= '0;
                dur_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// ---------------------------------------------------------------------------
// tb_melody_sequencer
//
// Two sequencers (64-entry and 4-entry ROM) with TICK_DIV=4, GAP_TICKS=1.
// The expected behaviour of a song is expanded into a cycle-by-cycle timeline
// from the ROM contents: fetch/decode, handshake with a chosen stall, duration
// and gap lengths, end marker or end of ROM. Each timeline entry also says
// how to drive tone_ready and stop during that cycle.
// ---------------------------------------------------------------------------
module tb_melody_sequencer;

    localparam int TICK = 4;
    localparam int GAP  = 1;
`ifdef MELODY_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct {
        bit busy;
        bit valid;
        bit en;
        bit done;
        bit stop;
        bit chk_period;
        bit chk_idx;
        bit chk_addr;
        int ready;
        int period;
        int idx;
        int addr;
    } exp_t;

    logic clk;
    logic rst;
    logic start;
    logic stop;
    logic ready;
    bit   sel;

    logic       start_a, stop_a, busy_a, done_a;
    logic [5:0] note_idx_a;
    logic       start_b, stop_b, busy_b, done_b;
    logic [1:0] note_idx_b;

    logic [19:0] rom_a [64];
    logic [19:0] rom_b [4];
    logic [19:0] song  [64];
    int          stall [64];
    exp_t        exp_q [$];

    int n_checks;
    int n_fail;

    melody_sequencer_if #(.ADDR_W(6)) bus_a ();
    melody_sequencer_if #(.ADDR_W(2)) bus_b ();

    melody_sequencer #(.ADDR_W(6), .TICK_DIV(TICK), .GAP_TICKS(GAP)) dut_a (
        .clk_100m (clk),
        .btn_rst  (rst),
        .start    (start_a),
        .stop     (stop_a),
        .bus      (bus_a),
        .busy     (busy_a),
        .note_idx (note_idx_a),
        .song_done(done_a)
    );

    melody_sequencer #(.ADDR_W(2), .TICK_DIV(TICK), .GAP_TICKS(GAP)) dut_b (
        .clk_100m (clk),
        .btn_rst  (rst),
        .start    (start_b),
        .stop     (stop_b),
        .bus      (bus_b),
        .busy     (busy_b),
        .note_idx (note_idx_b),
        .song_done(done_b)
    );

    assign start_a = start && !sel;
    assign stop_a  = stop  && !sel;
    assign start_b = start && sel;
    assign stop_b  = stop  && sel;
    assign bus_a.tone_ready = ready;
    assign bus_b.tone_ready = ready;

    // Synchronous ROMs: data follows the address by one clock.
    always @(posedge clk) begin
        bus_a.rom_data <= rom_a[bus_a.rom_addr];
        bus_b.rom_data <= rom_b[bus_b.rom_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t blank(input bit busy);
        exp_t r;
        r.busy = busy; r.valid = 0; r.en = 0; r.done = 0; r.stop = 0;
        r.chk_period = 0; r.chk_idx = 0; r.chk_addr = 0;
        r.ready = -1; r.period = 0; r.idx = 0; r.addr = 0;
        return r;
    endfunction

    // Expand the song in 'song' into the expected per-cycle timeline that
    // follows the start edge, ending with one idle cycle.
    task automatic build_timeline(input int aw);
        exp_t r;
        int   addr, per, dur;
        int   max_addr = (1 << aw) - 1;
        int   passes = LOOP ? 2 : 1;
        exp_q.delete();
        for (int p = 0; p < passes; p++) begin
            addr = 0;
            forever begin
                r = blank(1); r.chk_addr = 1; r.addr = addr; exp_q.push_back(r);
                r = blank(1); exp_q.push_back(r);
                per = int'(song[addr][19:8]);
                dur = int'(song[addr][7:0]);
                if (dur == 0) begin
                    r = blank(1); r.done = 1; exp_q.push_back(r);
                    break;
                end
                if (per != 0) begin
                    for (int s = 0; s <= stall[addr]; s++) begin
                        r = blank(1); r.valid = 1; r.chk_period = 1; r.period = per;
                        r.chk_idx = 1; r.idx = addr; r.ready = (s == stall[addr]) ? 1 : 0;
                        exp_q.push_back(r);
                    end
                end
                for (int c = 0; c < dur * TICK; c++) begin
                    r = blank(1); r.en = (per != 0); r.chk_period = (per != 0);
                    r.period = per; r.chk_idx = 1; r.idx = addr;
                    exp_q.push_back(r);
                end
                for (int c = 0; c < GAP * TICK; c++) begin
                    r = blank(1); r.chk_idx = 1; r.idx = addr; exp_q.push_back(r);
                end
                r = blank(1); exp_q.push_back(r);
                if (addr == max_addr) begin
                    r = blank(1); r.done = 1; exp_q.push_back(r);
                    break;
                end
                addr++;
            end
        end
        if (LOOP) begin
            r = blank(1); r.chk_addr = 1; r.addr = 0; r.stop = 1; exp_q.push_back(r);
        end
        r = blank(0); exp_q.push_back(r);
    endtask

    task automatic load_rom(input bit which);
        for (int i = 0; i < 64; i++) begin
            if (which) begin
                if (i < 4) rom_b[i] = song[i];
            end else begin
                rom_a[i] = song[i];
            end
        end
    endtask

    task automatic clear_song();
        for (int i = 0; i < 64; i++) begin
            song[i]  = 20'h0;
            stall[i] = 0;
        end
    endtask

    // Pulse start, then walk the timeline one cycle at a time, checking at
    // the falling edge and driving the inputs for that cycle. Extra start
    // pulses while busy must be ignored.
    task automatic applyStimulus(input bit which);
        exp_t        r;
        logic [31:0] o_busy, o_valid, o_en, o_done, o_period, o_idx, o_addr;
        sel = which;
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            r        = exp_q[i];
            o_busy   = 32'(which ? busy_b : busy_a);
            o_valid  = 32'(which ? bus_b.tone_valid : bus_a.tone_valid);
            o_en     = 32'(which ? bus_b.tone_en : bus_a.tone_en);
            o_done   = 32'(which ? done_b : done_a);
            o_period = 32'(which ? bus_b.tone_period : bus_a.tone_period);
            o_idx    = which ? 32'(note_idx_b) : 32'(note_idx_a);
            o_addr   = which ? 32'(bus_b.rom_addr) : 32'(bus_a.rom_addr);
            checkOutput($sformatf("busy@%0d", i), o_busy, 32'(r.busy));
            checkOutput($sformatf("tone_valid@%0d", i), o_valid, 32'(r.valid));
            checkOutput($sformatf("tone_en@%0d", i), o_en, 32'(r.en));
            checkOutput($sformatf("song_done@%0d", i), o_done, 32'(r.done));
            if (r.chk_period) checkOutput($sformatf("tone_period@%0d", i), o_period, 32'(r.period));
            if (r.chk_idx)    checkOutput($sformatf("note_idx@%0d", i), o_idx, 32'(r.idx));
            if (r.chk_addr)   checkOutput($sformatf("rom_addr@%0d", i), o_addr, 32'(r.addr));
            start = r.busy && ($urandom_range(0, 7) == 0);
            stop  = r.stop;
            ready = (r.ready < 0) ? 1'($urandom_range(0, 1)) : 1'(r.ready);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic set_basic_song();
        clear_song();
        song[0] = 20'h17C03;
        song[1] = 20'h0BE02;
        song[2] = 20'h00000;
    endtask

    initial begin
        int k, cnt, n_notes;
        n_checks = 0;
        n_fail   = 0;
        start = 0; stop = 0; ready = 1; sel = 0;
        clear_song();
        load_rom(0);
        load_rom(1);

        $display("[TB] reset state");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_valid", 32'(bus_a.tone_valid), 32'd0);
        checkOutput("rst_en", 32'(bus_a.tone_en), 32'd0);
        checkOutput("rst_done", 32'(done_a), 32'd0);
        checkOutput("rst_period", 32'(bus_a.tone_period), 32'd0);
        checkOutput("rst_idx", 32'(note_idx_a), 32'd0);
        checkOutput("rst_addr", 32'(bus_a.rom_addr), 32'd0);
        checkOutput("rst_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic two-note song");
        set_basic_song();
        load_rom(0);
        build_timeline(6);
        applyStimulus(0);

        $display("[TB] handshake stall");
        stall[0] = 5;
        stall[1] = 2;
        build_timeline(6);
        applyStimulus(0);

        $display("[TB] rest entry");
        clear_song();
        song[0] = 20'h00002;
        song[1] = 20'h17C01;
        load_rom(0);
        build_timeline(6);
        applyStimulus(0);

        $display("[TB] stop during note 1 then replay");
        set_basic_song();
        load_rom(0);
        build_timeline(6);
        k = -1; cnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].en && exp_q[i].idx == 1) begin
                cnt++;
                if (cnt == 3) begin k = i; break; end
            end
        end
        exp_q = exp_q[0:k];
        exp_q[k].stop = 1'b1;
        exp_q.push_back(blank(0));
        applyStimulus(0);
        build_timeline(6);
        applyStimulus(0);

        $display("[TB] start and stop together while idle");
        sel = 0;
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("idle_busy%0d", i), 32'(busy_a), 32'd0);
            checkOutput($sformatf("idle_valid%0d", i), 32'(bus_a.tone_valid), 32'd0);
            @(negedge clk);
        end

        $display("[TB] random songs");
        for (int t = 0; t < 6; t++) begin
            clear_song();
            n_notes = $urandom_range(1, 5);
            for (int i = 0; i < n_notes; i++) begin
                song[i][19:8] = ($urandom_range(0, 3) == 0) ? 12'h0 : 12'($urandom_range(1, 4095));
                song[i][7:0]  = 8'($urandom_range(1, 3));
                stall[i]      = $urandom_range(0, 3);
            end
            load_rom(0);
            build_timeline(6);
            applyStimulus(0);
        end

        $display("[TB] full ROM without end marker");
        clear_song();
        for (int i = 0; i < 4; i++) begin
            song[i][19:8] = ($urandom_range(0, 3) == 0) ? 12'h0 : 12'($urandom_range(1, 4095));
            song[i][7:0]  = 8'($urandom_range(1, 2));
            stall[i]      = $urandom_range(0, 2);
        end
        load_rom(1);
        build_timeline(2);
        applyStimulus(1);

        $display("[TB] asynchronous reset mid-note");
        set_basic_song();
        load_rom(0);
        build_timeline(6);
        k = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].en && exp_q[i].idx == 1) begin k = i + 3; break; end
        end
        exp_q = exp_q[0:k];
        applyStimulus(0);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_busy", 32'(busy_a), 32'd0);
        checkOutput("arst_en", 32'(bus_a.tone_en), 32'd0);
        checkOutput("arst_valid", 32'(bus_a.tone_valid), 32'd0);
        checkOutput("arst_period", 32'(bus_a.tone_period), 32'd0);
        checkOutput("arst_idx", 32'(note_idx_a), 32'd0);
        checkOutput("arst_addr", 32'(bus_a.rom_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_arst_busy", 32'(busy_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
